dma_ib_arbiter: RTL and testbench

DMA_IB_ARBITER -- requirements
Module: dma_ib_arbiter

---
 rtl/dma_ib_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dma_ib_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ib_arbiter.sv
// dma_ib_arbiter: round-robin arbiter that merges NSRC 64-bit beat streams
// into one inbound DMA stream. Frames longer than MAX_BEATS are cut short
// with an error-flagged last beat, and the rest of the frame is drained.
module dma_ib_arbiter #(
    parameter int NSRC      = 2,
    parameter int MAX_BEATS = 4096
) (
    input  logic                 dmaClk,
    input  logic                 dmaRst,
    input  logic [NSRC-1:0]      src_enable,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [64*NSRC-1:0]   src_data,
    input  logic [NSRC-1:0]      src_last,
    output logic [NSRC-1:0]      src_ready,
    output logic                 dma_valid,
    output logic [63:0]          dma_data,
    output logic                 dma_last,
    output logic [7:0]           dma_dest,
    output logic                 dma_err,
    input  logic                 dma_ready,
    output logic                 arb_busy,
    output logic [16*NSRC-1:0]   frame_count,
    output logic [15:0]          trunc_count
);

    localparam int GW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [15:0]   frame_cnt_q [NSRC];
    logic [15:0]   trunc_cnt_q;

    logic [63:0]   dataArr [NSRC];
    logic [NSRC-1:0] req;
    logic [GW-1:0] pickIdx;
    int            bestDist;
    logic          atMax;
    logic          accept;
    logic          frameInc;
    logic          truncInc;

    // Unpack the flat source data bus and expose the per-source counters.
    for (genvar i = 0; i < NSRC; i++) begin : g_unpack
        assign dataArr[i]              = src_data[64*i +: 64];
        assign frame_count[16*i +: 16] = frame_cnt_q[i];
    end

    assign req         = src_valid & src_enable;
    assign trunc_count = trunc_cnt_q;
    assign arb_busy    = !dmaRst && (state_q != IDLE);

    // Round-robin pick: the requester nearest above last_grant (with wrap) wins.
    always_comb begin
        bestDist = NSRC;
        pickIdx  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (req[i] && (((i + 2*NSRC - 1 - int'(last_grant_q)) % NSRC) < bestDist)) begin
                bestDist = (i + 2*NSRC - 1 - int'(last_grant_q)) % NSRC;
                pickIdx  = GW'(i);
            end
        end
    end

    // Combinational pass-through of the granted source; everything is quiet while in reset or IDLE.
    always_comb begin
        src_ready = '0;
        dma_valid = 1'b0;
        dma_data  = '0;
        dma_last  = 1'b0;
        dma_dest  = '0;
        dma_err   = 1'b0;
        accept    = 1'b0;
        atMax     = (beat_cnt_q == LAST_BEAT);
        if (!dmaRst) begin
            case (state_q)
                STREAM: begin
                    dma_valid          = src_valid[grant_q];
                    dma_data           = dataArr[grant_q];
                    dma_dest           = 8'(grant_q);
                    src_ready[grant_q] = dma_ready;
                    accept             = dma_valid && dma_ready;
                    dma_last           = dma_valid && (src_last[grant_q] || atMax);
                    dma_err            = dma_valid && atMax;
                end
                FLUSH: begin
                    src_ready[grant_q] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic: grant in IDLE, count beats in STREAM, drain the tail of a cut frame in FLUSH.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        frameInc     = 1'b0;
        truncInc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d      = pickIdx;
                    last_grant_d = pickIdx;
                    beat_cnt_d   = '0;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (atMax) begin
                        truncInc = 1'b1;
                        if (src_last[grant_q]) begin
                            frameInc = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d  = FLUSH;
                        end
                    end else if (src_last[grant_q]) begin
                        frameInc = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (src_valid[grant_q] && src_last[grant_q]) begin
                    frameInc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and beat-counter registers.
    always_ff @(posedge dmaClk) begin
        if (dmaRst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NSRC - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Per-source completed-frame counters (wrap) and saturating truncation counter.
    always_ff @(posedge dmaClk) begin
        if (dmaRst) begin
            for (int i = 0; i < NSRC; i++) frame_cnt_q[i] <= '0;
            trunc_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (frameInc && (grant_q == GW'(i))) frame_cnt_q[i] <= frame_cnt_q[i] + 16'd1;
            end
            if (truncInc && (trunc_cnt_q != 16'hFFFF)) trunc_cnt_q <= trunc_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_dma_ib_arbiter.sv
// Testbench for dma_ib_arbiter (NSRC=2, MAX_BEATS=8). Source frames are held
// in queues; a round-robin frame-level model predicts the outbound beat stream.
module tb_dma_ib_arbiter;

    localparam int NS   = 2;
    localparam int MAXB = 8;
    localparam int BUDGET = 2000;

    typedef struct { logic [63:0] data; logic last; } beat_t;
    typedef struct { logic [63:0] data; logic last; logic err; logic [7:0] dest; } exp_t;

    logic              dmaClk = 1'b0;
    logic              dmaRst;
    logic [NS-1:0]     src_enable;
    logic [NS-1:0]     src_valid;
    logic [64*NS-1:0]  src_data;
    logic [NS-1:0]     src_last;
    logic [NS-1:0]     src_ready;
    logic              dma_valid;
    logic [63:0]       dma_data;
    logic              dma_last;
    logic [7:0]        dma_dest;
    logic              dma_err;
    logic              dma_ready;
    logic              arb_busy;
    logic [16*NS-1:0]  frame_count;
    logic [15:0]       trunc_count;

    beat_t srcQ [NS][$];
    int    frameLen [NS][$];
    exp_t  expQ [$];
    int    expFrames [NS];
    int    expTrunc;
    int    modelLast;
    logic [NS-1:0] enMask;
    int    errors = 0;
    int    checks = 0;

    dma_ib_arbiter #(.NSRC(NS), .MAX_BEATS(MAXB)) dut (
        .dmaClk(dmaClk), .dmaRst(dmaRst), .src_enable(src_enable), .src_valid(src_valid),
        .src_data(src_data), .src_last(src_last), .src_ready(src_ready), .dma_valid(dma_valid),
        .dma_data(dma_data), .dma_last(dma_last), .dma_dest(dma_dest), .dma_err(dma_err),
        .dma_ready(dma_ready), .arb_busy(arb_busy), .frame_count(frame_count),
        .trunc_count(trunc_count)
    );

    always #5 dmaClk = ~dmaClk;

    task automatic model_reset();
        modelLast = NS - 1;
        expTrunc  = 0;
        for (int s = 0; s < NS; s++) expFrames[s] = 0;
    endtask

    task automatic add_frame(input int s, input int len);
        beat_t b;
        frameLen[s].push_back(len);
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, 8'(s), 8'(frameLen[s].size()), 16'(i)};
            b.last = (i == len - 1);
            srcQ[s].push_back(b);
        end
    endtask

    // Frame-level round robin over enabled sources that still have frames queued.
    task automatic build_expected();
        int off [NS];
        int pick, len, n;
        bit found;
        exp_t e;
        for (int s = 0; s < NS; s++) off[s] = 0;
        forever begin
            found = 0;
            pick  = 0;
            for (int k = 1; k <= NS; k++) begin
                if (!found && enMask[(modelLast + k) % NS] && frameLen[(modelLast + k) % NS].size() > 0) begin
                    found = 1;
                    pick  = (modelLast + k) % NS;
                end
            end
            if (!found) break;
            len = frameLen[pick].pop_front();
            n   = (len < MAXB) ? len : MAXB;
            for (int b = 0; b < n; b++) begin
                e.data = srcQ[pick][off[pick] + b].data;
                e.last = (b == n - 1);
                e.err  = (b == MAXB - 1);
                e.dest = 8'(pick);
                expQ.push_back(e);
            end
            off[pick] += len;
            expFrames[pick]++;
            if (len >= MAXB) expTrunc++;
            modelLast = pick;
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (expQ.size() > 0);
        for (int s = 0; s < NS; s++) if (enMask[s] && srcQ[s].size() > 0) p = 1;
        return p;
    endfunction

    // Drive queued frames, check every outbound beat and the counters at the end.
    // mode 0: ready always 1, 1: ready toggles, 2: ready random. endCyc >= 0 checks throughput.
    task automatic run(input string name, input int mode, input int gap, input int endCyc);
        int cyc, lastAcc;
        logic [NS-1:0] adv, expRdy;
        exp_t e;
        cyc = 0;
        lastAcc = -1;
        while (pending() && cyc < BUDGET) begin
            @(negedge dmaClk);
            case (mode)
                0: dma_ready = 1'b1;
                1: dma_ready = (cyc % 2 == 0);
                default: dma_ready = ($urandom_range(0, 3) != 0);
            endcase
            src_enable = enMask;
            for (int s = 0; s < NS; s++) begin
                if (srcQ[s].size() > 0 && (gap == 0 || $urandom_range(0, 99) >= gap)) begin
                    src_valid[s]          = 1'b1;
                    src_data[64*s +: 64]  = srcQ[s][0].data;
                    src_last[s]           = srcQ[s][0].last;
                end else begin
                    src_valid[s] = 1'b0;
                    src_last[s]  = 1'b0;
                end
            end
            #1;
            if (dma_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s extra_beat: got dma_valid=1 data=%h, required no beat", name, dma_data);
                end else begin
                    expRdy = dma_ready ? (NS'(1) << expQ[0].dest) : '0;
                    checks++;
                    if (src_ready !== expRdy) begin
                        errors++;
                        $display("[TB] FAIL %s src_ready: got %b, required %b", name, src_ready, expRdy);
                    end
                    if (dma_ready) begin
                        e = expQ.pop_front();
                        checks++;
                        if ({dma_data, dma_last, dma_err, dma_dest} !== {e.data, e.last, e.err, e.dest}) begin
                            errors++;
                            $display("[TB] FAIL %s beat: got data=%h last=%b err=%b dest=%0d, required data=%h last=%b err=%b dest=%0d",
                                     name, dma_data, dma_last, dma_err, dma_dest, e.data, e.last, e.err, e.dest);
                        end
                        lastAcc = cyc;
                    end
                end
            end
            adv = src_valid & src_ready;
            @(posedge dmaClk);
            for (int s = 0; s < NS; s++) if (adv[s]) void'(srcQ[s].pop_front());
            cyc++;
        end
        #1;
        for (int s = 0; s < NS; s++) begin
            if (srcQ[s].size() == 0) begin
                src_valid[s] = 1'b0;
                src_last[s]  = 1'b0;
            end
        end
        if (cyc >= BUDGET) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got %0d cycles with %0d beats outstanding, required completion", name, cyc, expQ.size());
        end
        for (int s = 0; s < NS; s++) begin
            checks++;
            if (frame_count[16*s +: 16] !== 16'(expFrames[s])) begin
                errors++;
                $display("[TB] FAIL %s frame_count[%0d]: got %0d, required %0d", name, s, frame_count[16*s +: 16], expFrames[s]);
            end
        end
        checks++;
        if (trunc_count !== 16'(expTrunc)) begin
            errors++;
            $display("[TB] FAIL %s trunc_count: got %0d, required %0d", name, trunc_count, expTrunc);
        end
        if (endCyc >= 0) begin
            checks++;
            if (lastAcc != endCyc) begin
                errors++;
                $display("[TB] FAIL %s last_beat_cycle: got %0d, required %0d", name, lastAcc, endCyc);
            end
        end
    endtask

    task automatic test_reset();
        dmaRst     = 1'b1;
        src_enable = '1;
        src_valid  = '1;
        src_last   = '0;
        src_data   = '0;
        dma_ready  = 1'b1;
        repeat (2) @(posedge dmaClk);
        @(negedge dmaClk);
        #1;
        checks++;
        if ({dma_valid, dma_last, dma_err, arb_busy, dma_dest, src_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b last=%b err=%b busy=%b dest=%0d ready=%b, required all 0",
                     dma_valid, dma_last, dma_err, arb_busy, dma_dest, src_ready);
        end
        checks++;
        if ({frame_count, trunc_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got frames=%h trunc=%0d, required 0", frame_count, trunc_count);
        end
        dmaRst    = 1'b0;
        src_valid = '0;
        model_reset();
        @(negedge dmaClk);
        #1;
        checks++;
        if ({dma_valid, arb_busy, src_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got valid=%b busy=%b ready=%b, required 0", dma_valid, arb_busy, src_ready);
        end
    endtask

    task automatic test_two_sources();
        enMask = '1;
        add_frame(0, 3);
        add_frame(1, 3);
        build_expected();
        run("two_sources", 0, 0, 7);
    endtask

    task automatic test_round_robin();
        enMask = '1;
        for (int i = 0; i < 3; i++) begin
            add_frame(0, 2);
            add_frame(1, 2);
        end
        build_expected();
        run("round_robin", 0, 0, 17);
    endtask

    task automatic test_truncation();
        enMask = '1;
        add_frame(0, 12);
        build_expected();
        run("truncation", 0, 0, -1);
    endtask

    task automatic test_ready_toggle();
        enMask = '1;
        add_frame(1, 4);
        build_expected();
        run("ready_toggle", 1, 0, -1);
    endtask

    task automatic test_enable();
        enMask = 2'b01;
        add_frame(0, 2);
        add_frame(0, 2);
        add_frame(1, 3);
        build_expected();
        run("enable_off", 0, 0, -1);
        enMask = 2'b11;
        build_expected();
        run("enable_on", 0, 0, -1);
    endtask

    task automatic test_random();
        enMask = '1;
        add_frame(0, 7);
        add_frame(1, 8);
        add_frame(0, 9);
        add_frame(1, 1);
        for (int k = 0; k < 10; k++) add_frame($urandom_range(0, 1), $urandom_range(1, 12));
        build_expected();
        run("random", 2, 0, -1);
    endtask

    task automatic test_gaps();
        enMask = '1;
        add_frame(0, 10);
        for (int k = 0; k < 4; k++) add_frame(0, $urandom_range(1, 12));
        build_expected();
        run("gaps", 2, 30, -1);
    endtask

    task automatic test_reset_midframe();
        src_enable = '1;
        dma_ready  = 1'b1;
        @(negedge dmaClk);
        src_valid          = 2'b01;
        src_last           = '0;
        src_data[63:0]     = 64'hA0;
        @(negedge dmaClk);
        @(negedge dmaClk);
        src_data[63:0]     = 64'hA1;
        dmaRst             = 1'b1;
        #1;
        checks++;
        if ({dma_valid, arb_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midframe_during_reset: got valid=%b busy=%b, required 0 0", dma_valid, arb_busy);
        end
        @(negedge dmaClk);
        dmaRst    = 1'b0;
        src_valid = 2'b11;
        src_data[63:0] = 64'hA2;
        #1;
        checks++;
        if ({dma_valid, arb_busy, dma_last} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midframe_after_reset: got valid=%b busy=%b last=%b, required 0 0 0", dma_valid, arb_busy, dma_last);
        end
        checks++;
        if ({frame_count, trunc_count} !== '0) begin
            errors++;
            $display("[TB] FAIL midframe_counters: got frames=%h trunc=%0d, required 0", frame_count, trunc_count);
        end
        @(negedge dmaClk);
        #1;
        checks++;
        if ({dma_valid, dma_dest} !== {1'b1, 8'd0}) begin
            errors++;
            $display("[TB] FAIL midframe_regrant: got valid=%b dest=%0d, required 1 0", dma_valid, dma_dest);
        end
        src_valid = '0;
        dmaRst    = 1'b1;
        @(negedge dmaClk);
        dmaRst    = 1'b0;
        model_reset();
    endtask

    initial begin
        dmaRst     = 1'b1;
        src_enable = '0;
        src_valid  = '0;
        src_last   = '0;
        src_data   = '0;
        dma_ready  = 1'b0;
        enMask     = '1;
        model_reset();
        test_reset();
        test_two_sources();
        test_round_robin();
        test_truncation();
        test_ready_toggle();
        test_enable();
        test_random();
        test_gaps();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
